// File: rtl/z_writeback.sv
// Writes a captured double-width ALU result back to the register file as one
// or two half-word bus cycles, with one-hot register enables.
module z_writeback #(
  parameter int BUS_W = 32,
  parameter int NREG  = 16
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [2*BUS_W-1:0] alu_result,
  input  logic [3:0]         dest_lo,
  input  logic [3:0]         dest_hi,
  input  logic               split,
  output logic               busy,
  output logic [BUS_W-1:0]   bus_out,
  output logic [NREG-1:0]    reg_en,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WR_LO = 2'b01,
    WR_HI = 2'b10
  } state_t;

  state_t             state_r, nextState_s;
  logic [2*BUS_W-1:0] z_r, zNext_s;
  logic [3:0]         destLo_r, destLoNext_s;
  logic [3:0]         destHi_r, destHiNext_s;
  logic               split_r, splitNext_s;
  logic               busyNext_s, doneNext_s;
  logic [BUS_W-1:0]   busNext_s;
  logic [NREG-1:0]    regEnNext_s;

  // Indices beyond NREG shift out and yield no enable at all.
  function automatic logic [NREG-1:0] decodeOneHot(input logic [3:0] idx);
    logic [NREG-1:0] oneHot;
    oneHot = {{(NREG-1){1'b0}}, 1'b1} << idx;
    return oneHot;
  endfunction

  // Next-state logic and capture of the writeback request.
  always_comb begin
    nextState_s  = state_r;
    zNext_s      = z_r;
    destLoNext_s = destLo_r;
    destHiNext_s = destHi_r;
    splitNext_s  = split_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          nextState_s  = WR_LO;
          zNext_s      = alu_result;
          destLoNext_s = dest_lo;
          destHiNext_s = dest_hi;
          splitNext_s  = split;
        end else begin
          nextState_s  = IDLE;
        end
      end
      WR_LO: begin
        if (split_r) begin
          nextState_s = WR_HI;
        end else begin
          nextState_s = IDLE;
        end
      end
      WR_HI:   nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered with no extra latency.
  always_comb begin
    busyNext_s  = 1'b0;
    doneNext_s  = 1'b0;
    busNext_s   = {BUS_W{1'b0}};
    regEnNext_s = {NREG{1'b0}};
    case (nextState_s)
      WR_LO: begin
        busyNext_s  = 1'b1;
        doneNext_s  = ~splitNext_s;
        busNext_s   = zNext_s[BUS_W-1:0];
        regEnNext_s = decodeOneHot(destLoNext_s);
      end
      WR_HI: begin
        busyNext_s  = 1'b1;
        doneNext_s  = 1'b1;
        busNext_s   = zNext_s[2*BUS_W-1:BUS_W];
        regEnNext_s = decodeOneHot(destHiNext_s);
      end
      default: begin
        busyNext_s  = 1'b0;
        doneNext_s  = 1'b0;
        busNext_s   = {BUS_W{1'b0}};
        regEnNext_s = {NREG{1'b0}};
      end
    endcase
  end

  // State, captured request and registered outputs; clr aborts any writeback at once.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r  <= IDLE;
      z_r      <= {(2*BUS_W){1'b0}};
      destLo_r <= 4'd0;
      destHi_r <= 4'd0;
      split_r  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bus_out  <= {BUS_W{1'b0}};
      reg_en   <= {NREG{1'b0}};
    end else begin
      state_r  <= nextState_s;
      z_r      <= zNext_s;
      destLo_r <= destLoNext_s;
      destHi_r <= destHiNext_s;
      split_r  <= splitNext_s;
      busy     <= busyNext_s;
      done     <= doneNext_s;
      bus_out  <= busNext_s;
      reg_en   <= regEnNext_s;
    end
  end

endmodule

// File: tb/tb_z_writeback.sv
// Directed self-checking bench for z_writeback.
module tb_z_writeback;

  logic        clk;
  logic        clr;
  logic        start;
  logic [63:0] alu_result;
  logic [3:0]  dest_lo;
  logic [3:0]  dest_hi;
  logic        split;
  logic        busy;
  logic [31:0] bus_out;
  logic [15:0] reg_en;
  logic        done;

  int tests;
  int fails;
  int doneCount;
  int expDone;

  z_writeback #(.BUS_W(32), .NREG(16)) dut (
    .clk(clk), .clr(clr), .start(start), .alu_result(alu_result),
    .dest_lo(dest_lo), .dest_hi(dest_hi), .split(split),
    .busy(busy), .bus_out(bus_out), .reg_en(reg_en), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chkOut(input string tag, input logic b, input logic d,
                        input logic [31:0] bo, input logic [15:0] en);
    chk({tag, "_busy"}, {63'd0, busy}, {63'd0, b});
    chk({tag, "_done"}, {63'd0, done}, {63'd0, d});
    chk({tag, "_bus"}, {32'd0, bus_out}, {32'd0, bo});
    chk({tag, "_en"}, {48'd0, reg_en}, {48'd0, en});
  endtask

  // Every-cycle one-hot check and done pulse counting.
  always @(negedge clk) begin
    chk("onehot0", {63'd0, $onehot0(reg_en)}, 64'd1);
    if (done === 1'b1) doneCount++;
  end

  initial begin
    tests = 0; fails = 0; doneCount = 0; expDone = 0;
    clr = 1'b0; start = 1'b0; alu_result = 64'd0;
    dest_lo = 4'd0; dest_hi = 4'd0; split = 1'b0;
    #12;
    chkOut("reset", 1'b0, 1'b0, 32'h0, 16'h0);

    // Basic split writeback, started at the first edge after reset release
    clr = 1'b1; start = 1'b1; alu_result = 64'h12345678_9ABCDEF0;
    dest_lo = 4'd2; dest_hi = 4'd5; split = 1'b1;
    tick();
    start = 1'b0;
    chkOut("s1_lo", 1'b1, 1'b0, 32'h9ABCDEF0, 16'h0004);
    tick();
    chkOut("s1_hi", 1'b1, 1'b1, 32'h12345678, 16'h0020);
    tick();
    chkOut("s1_idle", 1'b0, 1'b0, 32'h0, 16'h0);
    expDone += 1;

    // Low-half only
    start = 1'b1; alu_result = 64'hFFFFFFFF_00000001;
    dest_lo = 4'd15; dest_hi = 4'd3; split = 1'b0;
    tick();
    start = 1'b0;
    chkOut("s2_lo", 1'b1, 1'b1, 32'h00000001, 16'h8000);
    tick();
    chkOut("s2_idle", 1'b0, 1'b0, 32'h0, 16'h0);
    expDone += 1;

    // Same destination for both halves
    start = 1'b1; alu_result = 64'hAAAA5555_0F0F1234;
    dest_lo = 4'd7; dest_hi = 4'd7; split = 1'b1;
    tick();
    start = 1'b0;
    chkOut("s3_lo", 1'b1, 1'b0, 32'h0F0F1234, 16'h0080);
    tick();
    chkOut("s3_hi", 1'b1, 1'b1, 32'hAAAA5555, 16'h0080);
    tick();
    chkOut("s3_idle", 1'b0, 1'b0, 32'h0, 16'h0);
    expDone += 1;

    // start held high; inputs changed mid-operation
    start = 1'b1; alu_result = 64'h11112222_33334444;
    dest_lo = 4'd1; dest_hi = 4'd6; split = 1'b1;
    tick();
    chkOut("s4_a_lo", 1'b1, 1'b0, 32'h33334444, 16'h0002);
    alu_result = 64'h55556666_77778888; dest_lo = 4'd10; dest_hi = 4'd11; split = 1'b0;
    tick();
    chkOut("s4_a_hi", 1'b1, 1'b1, 32'h11112222, 16'h0040);
    tick();
    chkOut("s4_gap1", 1'b0, 1'b0, 32'h0, 16'h0);
    tick();
    chkOut("s4_b_lo", 1'b1, 1'b1, 32'h77778888, 16'h0400);
    tick();
    chkOut("s4_gap2", 1'b0, 1'b0, 32'h0, 16'h0);
    tick();
    chkOut("s4_c_lo", 1'b1, 1'b1, 32'h77778888, 16'h0400);
    start = 1'b0;
    tick();
    chkOut("s4_idle", 1'b0, 1'b0, 32'h0, 16'h0);
    expDone += 3;

    // clr pulsed during WR_LO aborts the writeback
    start = 1'b1; alu_result = 64'hDEADBEEF_0BADF00D;
    dest_lo = 4'd3; dest_hi = 4'd9; split = 1'b1;
    tick();
    start = 1'b0;
    chkOut("s5_lo", 1'b1, 1'b0, 32'h0BADF00D, 16'h0008);
    #1 clr = 1'b0;
    #1 chkOut("s5_clr", 1'b0, 1'b0, 32'h0, 16'h0);
    #1 clr = 1'b1;
    tick();
    chkOut("s5_nohi", 1'b0, 1'b0, 32'h0, 16'h0);

    // Next start after abort is served normally
    start = 1'b1; alu_result = 64'h00000000_CAFEF00D;
    dest_lo = 4'd1; dest_hi = 4'd4; split = 1'b0;
    tick();
    start = 1'b0;
    chkOut("s6_lo", 1'b1, 1'b1, 32'hCAFEF00D, 16'h0002);
    tick();
    chkOut("s6_idle", 1'b0, 1'b0, 32'h0, 16'h0);
    expDone += 1;

    @(negedge clk);
    #1;
    chk("done_count", 64'(doneCount), 64'(expDone));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/z_writeback.md
Z_WRITEBACK -- requirements
Module: z_writeback

Interface
REQ-001 The block SHALL have parameter BUS_W, default 32, meaning the width of the bus half-word and of bus_out.
REQ-002 The block SHALL have parameter NREG, default 16, meaning the number of destination registers, one bit of reg_en per register.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port clr, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to write back a result.
REQ-006 The block SHALL have port alu_result, input, 2*BUS_W bits: the selected ALU output (Z value).
REQ-007 The block SHALL have port dest_lo, input, 4 bits: register index for the low half.
REQ-008 The block SHALL have port dest_hi, input, 4 bits: register index for the high half.
REQ-009 The block SHALL have port split, input, 1 bit: 1 writes both halves, 0 writes the low half only.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a writeback is in progress.
REQ-011 The block SHALL have port bus_out, output, BUS_W bits: the half-word driven to the register bus.
REQ-012 The block SHALL have port reg_en, output, NREG bits: one-hot register write enable.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse on the final write cycle.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WR_LO and WR_HI.
REQ-015 In IDLE with start=1 at a rising edge, the block SHALL capture alu_result into the internal 64-bit Z register, capture dest_lo, dest_hi and split, and move to WR_LO.
REQ-016 start SHALL be ignored in WR_LO and WR_HI, and captured values SHALL NOT change until the FSM returns to IDLE.
REQ-017 In WR_LO, bus_out SHALL equal Z[BUS_W-1:0] and reg_en SHALL equal the one-hot decode of captured dest_lo.
REQ-018 From WR_LO, the FSM SHALL go to WR_HI if captured split=1, else to IDLE.
REQ-019 In WR_HI, bus_out SHALL equal Z[2*BUS_W-1:BUS_W] and reg_en SHALL equal the one-hot decode of captured dest_hi; the next state SHALL be IDLE.
REQ-020 done SHALL be 1 only in the last write state (WR_LO if split=0, WR_HI if split=1), for exactly one cycle per accepted start.
REQ-021 busy SHALL be 1 in WR_LO and WR_HI and 0 in IDLE.
REQ-022 Latency: the first write SHALL occur in the cycle after start is accepted, and the next start SHALL be accepted no earlier than the cycle after done.
REQ-023 In IDLE, reg_en SHALL be all zeros and bus_out SHALL be all zeros.
REQ-024 reg_en SHALL never have more than one bit set in any cycle.
REQ-025 If dest_hi equals dest_lo with split=1, the same reg_en bit SHALL be asserted in two consecutive cycles (low half first, then high half); no special handling.
REQ-026 All outputs SHALL be driven from registered state only (no combinational path from inputs to outputs).

Reset
REQ-027 clr=0 SHALL immediately force IDLE, Z=0, busy=0, done=0, reg_en=0 and bus_out=0, regardless of clk.
REQ-028 If clr is asserted during WR_LO or WR_HI, the writeback SHALL be aborted with no further reg_en pulse.
REQ-029 The first start SHALL be accepted at the first rising edge after clr deasserts.

Verification
REQ-030 Scenario: start=1, alu_result=0x12345678_9ABCDEF0, dest_lo=2, dest_hi=5, split=1 -> cycle+1: bus_out=0x9ABCDEF0 and reg_en=0x0004; cycle+2: bus_out=0x12345678, reg_en=0x0020 and done=1; cycle+3: IDLE with outputs 0.
REQ-031 Scenario: split=0, dest_lo=15, alu_result=0xFFFFFFFF_00000001 -> a single cycle with bus_out=0x00000001, reg_en=0x8000 and done=1; no high-half cycle.
REQ-032 Scenario: start held high continuously -> writebacks are accepted every 3 cycles with split=1 and every 2 cycles with split=0; inputs changed mid-operation do not alter the outputs.
REQ-033 Scenario: clr pulsed low mid-WR_LO -> outputs go to 0 asynchronously; no WR_HI cycle follows; the next start is served normally.
REQ-034 Scenario: dest_lo=dest_hi=7, split=1 -> reg_en=0x0080 in two consecutive cycles, carrying the low half then the high half.
REQ-035 Throughout all scenarios, the bench SHALL check that reg_en has at most one bit set in every cycle and that done equals 1 exactly once per accepted start.
